// File: rtl/dcache_pkg.sv
// Shared types and constants for the L1 data cache line mover.
package dcache_pkg;

    localparam int LINE_BEATS = 8;
    localparam int SET_W      = 7;
    localparam int BEAT_W     = 64;
    localparam int ADDR_W     = SET_W + 6;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        EVICT,
        DONE
    } mover_state_t;

    // Byte address of one 64-bit word inside the data array
    function automatic logic [ADDR_W-1:0] composeAddr(input logic [SET_W-1:0] setIdx,
                                                      input logic [2:0]       beat);
        return {setIdx, beat, 3'b000};
    endfunction

endpackage

// File: rtl/dcache_mover_fifo.sv
// Small write-back buffer for the line mover: DEPTH entries, need not be a power of two.
module dcache_mover_fifo #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign doPop  = pop && (count != '0);
    assign doPush = push && ((count != FULL_CNT) || doPop);
    assign head   = mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= bump(wrPtr);
            end
            if (doPop) rdPtr <= bump(rdPtr);
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dcache_line_mover.sv
// Refill/evict engine between memory and the L1 data array, one 64-byte line per command.
// Define DCACHE_MOVER_WRAP_EN for critical-word-first transfers starting at cmd_beat.
module dcache_line_mover #(
    parameter int LINE_BEATS = dcache_pkg::LINE_BEATS,
    parameter int SET_W      = dcache_pkg::SET_W,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_evict,
    input  logic [SET_W-1:0]              cmd_set,
    input  logic [2:0]                    cmd_beat,
    input  logic                          refill_valid,
    output logic                          refill_ready,
    input  logic [dcache_pkg::BEAT_W-1:0] refill_data,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [dcache_pkg::BEAT_W-1:0] wb_data,
    output logic                          wb_last,
    output logic                          done,
    output logic                          busy,
    output logic                          arr_req_valid,
    output logic [SET_W+5:0]              arr_req_bits_addr,
    output logic                          arr_req_bits_write,
    output logic [dcache_pkg::BEAT_W-1:0] arr_req_bits_wdata,
    output logic [7:0]                    arr_req_bits_wmask,
    output logic                          arr_req_bits_way_en,
    input  logic [dcache_pkg::BEAT_W-1:0] arr_resp
);
    import dcache_pkg::*;

    localparam int         CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] BEATS_CNT = 4'(LINE_BEATS);
    localparam logic [3:0] LAST_CNT  = 4'(LINE_BEATS - 1);

    mover_state_t     state;
    mover_state_t     nextState;
    logic [SET_W-1:0] setLat;
    logic [2:0]       beatCnt;
    logic [2:0]       startBeat;
    logic [3:0]       issuedCnt;
    logic [3:0]       poppedCnt;
    logic             inflight;
    logic             accept;
    logic             writeXfer;
    logic             readIssue;
    logic             fifoPop;
    logic [CNT_W-1:0] fifoCount;

`ifdef DCACHE_MOVER_WRAP_EN
    assign startBeat = cmd_beat;
`else
    logic [2:0] unusedBeat;
    assign unusedBeat = cmd_beat;
    assign startBeat  = 3'd0;
`endif

    // Read data lands one cycle after the request, so the inflight flag doubles as the push
    dcache_mover_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(BEAT_W)
    ) wbFifo (
        .clk     (clk),
        .reset   (reset),
        .push    (inflight),
        .pushData(arr_resp),
        .pop     (fifoPop),
        .head    (wb_data),
        .count   (fifoCount)
    );

    assign wb_valid = (fifoCount != '0);
    assign wb_last  = wb_valid && (poppedCnt == LAST_CNT);
    assign fifoPop  = wb_valid && wb_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            setLat    <= '0;
            beatCnt   <= '0;
            issuedCnt <= '0;
            poppedCnt <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= nextState;
            inflight <= readIssue;
            if (accept) begin
                setLat    <= cmd_set;
                beatCnt   <= startBeat;
                issuedCnt <= '0;
                poppedCnt <= '0;
            end else begin
                if (writeXfer || readIssue) begin
                    beatCnt <= beatCnt + 3'd1;
                    if (issuedCnt != BEATS_CNT) issuedCnt <= issuedCnt + 4'd1;
                end
                if (fifoPop && (poppedCnt != BEATS_CNT)) poppedCnt <= poppedCnt + 4'd1;
            end
        end
    end

    // Issue throttling looks only at registered occupancy, never at wb_ready
    always_comb begin
        nextState           = state;
        cmd_ready           = 1'b0;
        accept              = 1'b0;
        refill_ready        = 1'b0;
        writeXfer           = 1'b0;
        readIssue           = 1'b0;
        arr_req_valid       = 1'b0;
        arr_req_bits_addr   = '0;
        arr_req_bits_write  = 1'b0;
        arr_req_bits_wdata  = '0;
        arr_req_bits_wmask  = '0;
        arr_req_bits_way_en = 1'b0;

        unique case (state)
            IDLE: begin
                cmd_ready = ~reset;
                accept    = cmd_valid && cmd_ready;
                if (accept) nextState = cmd_evict ? EVICT : REFILL;
            end
            REFILL: begin
                refill_ready = 1'b1;
                writeXfer    = refill_valid;
                if (writeXfer && (issuedCnt == LAST_CNT)) nextState = DONE;
            end
            EVICT: begin
                readIssue = (issuedCnt < BEATS_CNT) &&
                            ((int'(fifoCount) + int'(inflight)) < FIFO_DEPTH);
                if (fifoPop && (poppedCnt == LAST_CNT)) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase

        if (writeXfer || readIssue) begin
            arr_req_valid       = 1'b1;
            arr_req_bits_addr   = composeAddr(setLat, beatCnt);
            arr_req_bits_way_en = 1'b1;
        end
        if (writeXfer) begin
            arr_req_bits_write = 1'b1;
            arr_req_bits_wdata = refill_data;
            arr_req_bits_wmask = 8'hFF;
        end
    end

endmodule
